// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one combinational AND/OR/XOR unit
// between NUM_REQ valid/ready requesters, with a one-entry tagged response register.
module logic_unit_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*32-1:0]     req_op_a,
    input  logic [NUM_REQ*32-1:0]     req_op_b,
    input  logic [NUM_REQ*2-1:0]      req_sel,
    output logic [31:0]               lu_operand_a,
    output logic [31:0]               lu_operand_b,
    output logic [1:0]                lu_sel,
    input  logic [31:0]               lu_result,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned SUM_W  = ID_W + 1;
    localparam logic [1:0]  SEL_BAD = 2'b11;

    logic [ID_W-1:0]        rr_ptr;
    logic                   can_issue_c;
    logic                   grant_valid_c;
    logic [ID_W-1:0]        grant_idx_c;
    logic [ID_W-1:0]        grant_off_c;
    logic [2*NUM_REQ-1:0]   rot_valid_c;
    logic [SUM_W-1:0]       grant_sum_c;
    logic                   sel_bad_c;

    // Slot is free when the response register is empty or draining this cycle
    assign can_issue_c = !resp_valid || resp_ready;

    // Round-robin search: rotate valids so rr_ptr lands at bit 0, take the lowest set bit
    always_comb begin
        rot_valid_c   = {req_valid, req_valid} >> rr_ptr;
        grant_valid_c = 1'b0;
        grant_off_c   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (rot_valid_c[j] && !grant_valid_c) begin
                grant_valid_c = 1'b1;
                grant_off_c   = ID_W'(j);
            end
        end
        if (!can_issue_c || rst) begin
            grant_valid_c = 1'b0;
        end
        grant_sum_c = {1'b0, rr_ptr} + {1'b0, grant_off_c};
        if (grant_sum_c >= SUM_W'(NUM_REQ)) begin
            grant_sum_c = grant_sum_c - SUM_W'(NUM_REQ);
        end
        grant_idx_c = grant_sum_c[ID_W-1:0];
    end

    // One-hot accept and shared-unit operand mux; idle drive is all zero
    always_comb begin
        req_ready    = '0;
        lu_operand_a = '0;
        lu_operand_b = '0;
        lu_sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid_c && (grant_idx_c == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                lu_operand_a = req_op_a[i*DATA_W +: DATA_W];
                lu_operand_b = req_op_b[i*DATA_W +: DATA_W];
                lu_sel       = req_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    assign sel_bad_c = (lu_sel == SEL_BAD);

    // Response register and round-robin pointer; new grant overrides a drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
            rr_ptr     <= '0;
        end else if (grant_valid_c) begin
            resp_valid <= 1'b1;
            resp_data  <= sel_bad_c ? '0 : lu_result;
            resp_id    <= grant_idx_c;
            resp_err   <= sel_bad_c;
            rr_ptr     <= (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares the single combinational logical unit (AND/OR/XOR) between NUM_REQ requesters, for example the execute stage, a debug port and a CSR bit-manipulation path.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants one request per cycle and drives the shared unit's operand and select inputs.
- The arbiter captures the unit's result into a one-entry response register, tagged with the requester id, and presents it through a valid/ready response port.
- Sits between the requesting pipeline stages and the logical unit instance.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester id; must be at least clog2(NUM_REQ).

Ports:
- clk, input, 1, core clock.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, per-requester accept; one-hot or zero.
- req_op_a, input, NUM_REQ*32, flat operand A vector; requester i uses bits [32i+31:32i].
- req_op_b, input, NUM_REQ*32, flat operand B vector, same packing as req_op_a.
- req_sel, input, NUM_REQ*2, flat select vector; 00=AND, 01=OR, 10=XOR.
- lu_operand_a, output, 32, to the shared unit's operand_a.
- lu_operand_b, output, 32, to the shared unit's operand_b.
- lu_sel, output, 2, to the shared unit's sel.
- lu_result, input, 32, from the shared unit's logical_result.
- resp_valid, output, 1, response register holds data.
- resp_ready, input, 1, consumer accepts the response.
- resp_data, output, 32, registered result.
- resp_id, output, ID_W, index of the requester that issued this result.
- resp_err, output, 1, the request used sel=11; resp_data is 0.

Behaviour:
- Reset values:
  - resp_valid=0, resp_data=0, resp_id=0, resp_err=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst is high.
  - Reset is asynchronous and takes effect mid-operation; any held response is dropped.
- Slot availability: can_issue = !resp_valid || resp_ready. The response register either is empty or is being drained this cycle.
- Arbitration (combinational):
  - If can_issue, grant the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only. All other bits are 0.
  - If can_issue=0, req_ready is all zero.
- Shared-unit drive:
  - lu_operand_a, lu_operand_b and lu_sel take the granted requester's fields.
  - When nothing is granted, they are driven to 0 (sel=00) to avoid toggling.
- Handshake:
  - A request transfers on a rising edge where req_valid[i] && req_ready[i].
  - Requesters must hold their fields stable until the transfer.
  - req_ready never depends on the same requester's req_valid combinationally, except through the arbitration priority.
- Latency: one cycle. A request accepted at edge N produces resp_valid=1 after edge N, carrying lu_result as sampled at edge N.
- Capture on transfer:
  - resp_data = lu_result, except resp_data = 0 when sel=11.
  - resp_id = grant index.
  - resp_err = (sel==11).
  - resp_valid = 1.
- Drain: if resp_valid && resp_ready and no new grant, resp_valid goes to 0. The other response fields hold their values.
- Simultaneous drain and grant: the new response replaces the old one in the same edge. Full throughput is one operation per cycle with no bubble.
- Backpressure: with resp_valid=1 and resp_ready=0, the response fields stay stable and no requests are accepted.
- Round-robin update: on each transfer, rr_ptr = (grant+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Starvation bound: a continuously valid requester is granted within NUM_REQ transfers.
- Grant-index edge cases:
  - Grant indices are always < NUM_REQ.
  - A pointer at NUM_REQ-1 wraps the search to 0.

Test Plan:
- Reset, single request:
  - Stimulus: assert rst mid-stream, release. Then req_valid=001, op_a=0xF0F0_F0F0, op_b=0x0FF0_0FF0, sel=00.
  - Response: req_ready=001 immediately; next cycle resp_valid=1, resp_data=0x00F0_00F0, resp_id=0, resp_err=0.
- Round-robin:
  - Stimulus: all three requesters valid continuously, resp_ready=1.
  - Response: grants 0,1,2,0,1,2 on consecutive cycles; resp_id follows one cycle later with no gaps.
- Backpressure:
  - Stimulus: response held with resp_ready=0 for 3 cycles while req_valid=110.
  - Response: req_ready=000 and resp_data/resp_id stable; on the cycle resp_ready=1, requester 1 is granted and the new result appears on the next cycle.
- Illegal select:
  - Stimulus: requester 2 issues sel=11, op_a=op_b=0xFFFF_FFFF.
  - Response: resp_err=1, resp_data=0, resp_id=2; the next legal sel=10 request gives resp_err=0.
- Operator sweep:
  - Stimulus: op_a=0xAAAA_5555, op_b=0xFFFF_0000 with sel=00/01/10.
  - Response: resp_data = 0xAAAA_0000 / 0xFFFF_5555 / 0x5555_5555 respectively.
- Reset mid-operation:
  - Stimulus: assert rst while resp_valid=1 and rr_ptr=2.
  - Response: resp_valid drops asynchronously to 0; after release, simultaneous requests 111 are granted to requester 0 first.
